// File: rtl/scope_sweep_scheduler_pkg.sv
// Shared encodings for the scope sweep scheduler: phases, FSM states and channel ids.
package scope_pkg;

  localparam logic [1:0] PH_CLEAN   = 2'b00;
  localparam logic [1:0] PH_FILL    = 2'b01;
  localparam logic [1:0] PH_DISPLAY = 2'b10;
  localparam logic [1:0] PH_END     = 2'b11;

  localparam logic CH1 = 1'b0;
  localparam logic CH2 = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAN,
    FILL,
    DISPLAY,
    HOLDOFF
  } state_t;

  // IDLE and HOLDOFF both report END so the datapath sees one "not sweeping" code.
  function automatic logic [1:0] phase_of(state_t s);
    case (s)
      CLEAN:   return PH_CLEAN;
      FILL:    return PH_FILL;
      DISPLAY: return PH_DISPLAY;
      default: return PH_END;
    endcase
  endfunction

endpackage

// File: rtl/scope_sweep_scheduler_if.sv
// Trigger/datapath bundle of the sweep scheduler; master = scheduler, slave = trigger blocks + datapath.
interface scope_sweep_if #(
  parameter int HOLDOFF_W = 16,
  parameter int CNT_W     = 16
);
  logic                 trig_ch1;
  logic                 trig_ch2;
  logic                 ch1_en;
  logic                 ch2_en;
  logic [HOLDOFF_W-1:0] holdoff;
  logic                 clean_done;
  logic                 fill_done;
  logic                 display_done;
  logic                 start_clean;
  logic                 start_fill;
  logic                 start_display;
  logic [1:0]           phase;
  logic                 ch_sel;
  logic                 busy;
  logic                 fill_timeout;
  logic [CNT_W-1:0]     sweep_count;
  logic                 auto_fired;

  modport master (
    input  trig_ch1, trig_ch2, ch1_en, ch2_en, holdoff,
    input  clean_done, fill_done, display_done,
    output start_clean, start_fill, start_display, phase, ch_sel,
    output busy, fill_timeout, sweep_count, auto_fired
  );

  modport slave (
    output trig_ch1, trig_ch2, ch1_en, ch2_en, holdoff,
    output clean_done, fill_done, display_done,
    input  start_clean, start_fill, start_display, phase, ch_sel,
    input  busy, fill_timeout, sweep_count, auto_fired
  );

endinterface

// File: rtl/scope_sweep_scheduler_rr_arbiter.sv
// Combinational 2-way round-robin: on a tie the channel that did not win last time is granted.
module scope_rr_arbiter (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_ch
);
  import scope_pkg::*;

  always_comb begin
    gnt_valid = |req;
    gnt_ch    = CH1;
    if (req == 2'b11) begin
      gnt_ch = ~last;
    end else if (req[1]) begin
      gnt_ch = CH2;
    end
  end

endmodule

// File: rtl/scope_sweep_scheduler.sv
// Sweep sequencer CLEAN->FILL->DISPLAY->HOLDOFF, one channel per sweep; start_clean 2 cycles after a trigger edge, all outputs registered.
// No backpressure: datapath done pulses advance the FSM, FILL aborts on timeout; macro AUTO_TRIGGER_EN adds the idle auto-trigger.
module scope_sweep_scheduler #(
  parameter int HOLDOFF_W    = 16,
  parameter int FILL_TIMEOUT = 4096,
`ifdef AUTO_TRIGGER_EN
  parameter int AUTO_TIMEOUT = 1000000,
`endif
  parameter int CNT_W        = 16
) (
  input logic           clk_25,
  input logic           rst,
  scope_sweep_if.master bus
);
  import scope_pkg::*;

  localparam int FT_W = (FILL_TIMEOUT > 1) ? $clog2(FILL_TIMEOUT) : 1;

  state_t               state_q, state_d;
  logic                 trig1_q, trig2_q;
  logic                 edge1, edge2;
  logic                 pend1_q, pend2_q, pend1_d, pend2_d;
  logic                 last_q;
  logic [FT_W-1:0]      fill_tmr_q;
  logic [HOLDOFF_W-1:0] hold_q;
  logic                 fill_expired;
  logic                 gnt_valid, gnt_ch;
  logic                 grant, grant_ch;
  logic                 go_fill, go_disp, timeout, swept, to_hold, to_idle;

  assign edge1        = bus.trig_ch1 & ~trig1_q;
  assign edge2        = bus.trig_ch2 & ~trig2_q;
  assign fill_expired = (fill_tmr_q == FT_W'(FILL_TIMEOUT - 1));

  scope_rr_arbiter u_arb (
    .req       ({pend2_q, pend1_q}),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_ch    (gnt_ch)
  );

`ifdef AUTO_TRIGGER_EN
  localparam int AT_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;

  logic [AT_W-1:0] idle_q;
  logic            auto_vld, auto_ch, idle_quiet, idle_hit, auto_grant;

  // Enables stand in for requests so the same fairness rule picks the auto channel.
  scope_rr_arbiter u_auto_arb (
    .req       ({bus.ch2_en, bus.ch1_en}),
    .last      (last_q),
    .gnt_valid (auto_vld),
    .gnt_ch    (auto_ch)
  );

  assign idle_quiet = (state_q == IDLE) && !pend1_q && !pend2_q;
  assign idle_hit   = idle_quiet && (idle_q == AT_W'(AUTO_TIMEOUT - 1));
  assign auto_grant = idle_hit && auto_vld;
  assign grant      = (state_q == IDLE) && (gnt_valid || auto_grant);
  assign grant_ch   = gnt_valid ? gnt_ch : auto_ch;

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      idle_q         <= '0;
      bus.auto_fired <= 1'b0;
    end else begin
      bus.auto_fired <= auto_grant;
      if (!idle_quiet) begin
        idle_q <= '0;
      end else if (!idle_hit) begin
        idle_q <= idle_q + 1'b1;
      end
    end
  end
`else
  assign grant          = (state_q == IDLE) && gnt_valid;
  assign grant_ch       = gnt_ch;
  assign bus.auto_fired = 1'b0;
`endif

  // A fresh edge beats the grant clear; a disabled channel drops its request outright.
  always_comb begin
    pend1_d = pend1_q;
    pend2_d = pend2_q;
    if (grant && (grant_ch == CH1)) pend1_d = 1'b0;
    if (grant && (grant_ch == CH2)) pend2_d = 1'b0;
    if (edge1) pend1_d = 1'b1;
    if (edge2) pend2_d = 1'b1;
    if (!bus.ch1_en) pend1_d = 1'b0;
    if (!bus.ch2_en) pend2_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    go_fill = 1'b0;
    go_disp = 1'b0;
    timeout = 1'b0;
    swept   = 1'b0;
    to_idle = 1'b0;
    case (state_q)
      IDLE:    if (grant) state_d = CLEAN;
      CLEAN:   if (bus.clean_done) begin
                 state_d = FILL;
                 go_fill = 1'b1;
               end
      FILL:    if (bus.fill_done) begin
                 state_d = DISPLAY;
                 go_disp = 1'b1;
               end else if (fill_expired) begin
                 state_d = HOLDOFF;
                 timeout = 1'b1;
               end
      DISPLAY: if (bus.display_done) begin
                 state_d = HOLDOFF;
                 swept   = 1'b1;
               end
      // Loaded value N gives N holdoff cycles, with 0 still costing one.
      HOLDOFF: if (hold_q <= HOLDOFF_W'(1)) begin
                 state_d = IDLE;
                 to_idle = 1'b1;
               end
      default: state_d = IDLE;
    endcase
    to_hold = timeout | swept;
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      trig1_q           <= 1'b0;
      trig2_q           <= 1'b0;
      pend1_q           <= 1'b0;
      pend2_q           <= 1'b0;
      last_q            <= CH2;
      bus.ch_sel        <= CH1;
      bus.start_clean   <= 1'b0;
      bus.start_fill    <= 1'b0;
      bus.start_display <= 1'b0;
      bus.fill_timeout  <= 1'b0;
      bus.busy          <= 1'b0;
      bus.sweep_count   <= '0;
      fill_tmr_q        <= '0;
      hold_q            <= '0;
    end else begin
      trig1_q           <= bus.trig_ch1;
      trig2_q           <= bus.trig_ch2;
      pend1_q           <= pend1_d;
      pend2_q           <= pend2_d;
      bus.start_clean   <= grant;
      bus.start_fill    <= go_fill;
      bus.start_display <= go_disp;
      bus.fill_timeout  <= timeout;
      if (grant) begin
        last_q     <= grant_ch;
        bus.ch_sel <= grant_ch;
        bus.busy   <= 1'b1;
      end else if (to_idle) begin
        bus.busy <= 1'b0;
      end
      if (swept) begin
        bus.sweep_count <= bus.sweep_count + 1'b1;
      end
      if (go_fill) begin
        fill_tmr_q <= '0;
      end else if (state_q == FILL) begin
        fill_tmr_q <= fill_tmr_q + 1'b1;
      end
      if (to_hold) begin
        hold_q <= bus.holdoff;
      end else if ((state_q == HOLDOFF) && (hold_q != '0)) begin
        hold_q <= hold_q - 1'b1;
      end
    end
  end

  assign bus.phase = phase_of(state_q);

endmodule

// File: tb/tb_scope_sweep_scheduler.sv
// Directed bench for scope_sweep_scheduler: vector table plus hand sequences for holdoff, timeout, enables and async reset.
module tb_scope_sweep_scheduler;

  logic clk_25 = 1'b0;
  logic rst    = 1'b1;

  always #5 clk_25 = ~clk_25;

  scope_sweep_if #(.HOLDOFF_W(16), .CNT_W(16)) bus ();

  scope_sweep_scheduler #(
    .HOLDOFF_W    (16),
    .FILL_TIMEOUT (16),
`ifdef AUTO_TRIGGER_EN
    .AUTO_TIMEOUT (100),
`endif
    .CNT_W        (16)
  ) dut (
    .clk_25 (clk_25),
    .rst    (rst),
    .bus    (bus)
  );

  typedef struct packed {
    logic        t1, t2, e1, e2, cd, fd, dd;
    logic [15:0] ho;
  } ins_t;

  typedef struct packed {
    logic        sc, sf, sd, ft, af;
    logic [1:0]  ph;
    logic        cs, busy;
    logic [15:0] cnt;
  } outs_t;

  typedef struct {
    logic  rst_first;
    ins_t  in;
    outs_t exp;
  } vec_t;

  vec_t  tbl[$];
  int    errors = 0;
  int    checks = 0;
  int    n;
  outs_t reset_o;

  function automatic ins_t mi(input int t1, t2, e1, e2, cd, fd, dd, ho);
    ins_t i;
    i.t1 = 1'(t1); i.t2 = 1'(t2); i.e1 = 1'(e1); i.e2 = 1'(e2);
    i.cd = 1'(cd); i.fd = 1'(fd); i.dd = 1'(dd); i.ho = 16'(ho);
    return i;
  endfunction

  function automatic outs_t mo(input int sc, sf, sd, ft, ph, cs, busy, cnt);
    outs_t o;
    o.sc = 1'(sc); o.sf = 1'(sf); o.sd = 1'(sd); o.ft = 1'(ft); o.af = 1'b0;
    o.ph = 2'(ph); o.cs = 1'(cs); o.busy = 1'(busy); o.cnt = 16'(cnt);
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.sc = bus.start_clean; o.sf = bus.start_fill; o.sd = bus.start_display;
    o.ft = bus.fill_timeout; o.af = bus.auto_fired; o.ph = bus.phase;
    o.cs = bus.ch_sel; o.busy = bus.busy; o.cnt = bus.sweep_count;
    return o;
  endfunction

  task automatic add(input int r, input ins_t i, input outs_t e);
    vec_t v;
    v.rst_first = 1'(r);
    v.in        = i;
    v.exp       = e;
    tbl.push_back(v);
  endtask

  task automatic apply(input ins_t i);
    bus.trig_ch1 = i.t1; bus.trig_ch2 = i.t2;
    bus.ch1_en = i.e1; bus.ch2_en = i.e2;
    bus.clean_done = i.cd; bus.fill_done = i.fd; bus.display_done = i.dd;
    bus.holdoff = i.ho;
  endtask

  task automatic tick();
    @(posedge clk_25);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    apply(mi(0, 0, 1, 1, 0, 0, 0, 0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    reset_o = mo(0, 0, 0, 0, 3, 0, 0, 0);

    // Basic ch1 sweep, holdoff 2, stray done pulses in the wrong states.
    add(0, mi(0,0,1,1,0,0,0,2), mo(0,0,0,0,3,0,0,0));
    add(0, mi(1,0,1,1,0,0,0,2), mo(0,0,0,0,3,0,0,0));
    add(0, mi(1,0,1,1,0,0,0,2), mo(1,0,0,0,0,0,1,0));
    add(0, mi(0,0,1,1,0,0,0,2), mo(0,0,0,0,0,0,1,0));
    add(0, mi(0,0,1,1,1,0,0,2), mo(0,1,0,0,1,0,1,0));
    add(0, mi(0,0,1,1,0,0,1,2), mo(0,0,0,0,1,0,1,0));
    add(0, mi(0,0,1,1,1,1,0,2), mo(0,0,1,0,2,0,1,0));
    add(0, mi(0,0,1,1,1,1,0,2), mo(0,0,0,0,2,0,1,0));
    add(0, mi(0,0,1,1,0,0,1,2), mo(0,0,0,0,3,0,1,1));
    add(0, mi(0,0,1,1,0,0,0,2), mo(0,0,0,0,3,0,1,1));
    add(0, mi(0,0,1,1,0,0,0,2), mo(0,0,0,0,3,0,0,1));
    // From reset: simultaneous triggers, round-robin ch1 -> ch2 -> ch1, holdoff 0.
    add(1, mi(1,1,1,1,0,0,0,0), mo(0,0,0,0,3,0,0,0));
    add(0, mi(1,1,1,1,0,0,0,0), mo(1,0,0,0,0,0,1,0));
    add(0, mi(0,0,1,1,1,0,0,0), mo(0,1,0,0,1,0,1,0));
    add(0, mi(0,0,1,1,0,1,0,0), mo(0,0,1,0,2,0,1,0));
    add(0, mi(0,0,1,1,0,0,1,0), mo(0,0,0,0,3,0,1,1));
    add(0, mi(0,0,1,1,0,0,0,0), mo(0,0,0,0,3,0,0,1));
    add(0, mi(0,0,1,1,0,0,0,0), mo(1,0,0,0,0,1,1,1));
    add(0, mi(0,0,1,1,1,0,0,0), mo(0,1,0,0,1,1,1,1));
    add(0, mi(0,0,1,1,0,1,0,0), mo(0,0,1,0,2,1,1,1));
    add(0, mi(0,0,1,1,0,0,1,0), mo(0,0,0,0,3,1,1,2));
    add(0, mi(1,1,1,1,0,0,0,0), mo(0,0,0,0,3,1,0,2));
    add(0, mi(1,1,1,1,0,0,0,0), mo(1,0,0,0,0,0,1,2));

    apply(mi(0, 0, 1, 1, 0, 0, 0, 2));
    rst = 1'b1;
    #2;
    chk("reset_outs", 32'(sample()), 32'(reset_o));
    tick();
    rst = 1'b0;

    foreach (tbl[i]) begin
      if (tbl[i].rst_first) do_reset();
      apply(tbl[i].in);
      tick();
      chk($sformatf("vec%0d", i), 32'(sample()), 32'(tbl[i].exp));
    end

    // Holdoff 5 on ch1 (mid-holdoff change ignored), then pending ch2 follows.
    apply(mi(0,0,1,1,1,0,0,0)); tick();
    apply(mi(0,0,1,1,0,1,0,0)); tick();
    apply(mi(0,0,1,1,0,0,1,5)); tick();
    chk("hold5_count", 32'(bus.sweep_count), 3);
    apply(mi(0,0,1,1,0,0,0,0));
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!(bus.busy && bus.phase == 2'b11)) break;
      n++;
      tick();
    end
    chk("hold5_cycles", 32'(n), 5);
    tick();
    chk("hold5_ch2_grant", 32'({bus.start_clean, bus.ch_sel}), 3);
    apply(mi(0,0,1,1,1,0,0,0)); tick();
    apply(mi(0,0,1,1,0,1,0,0)); tick();
    apply(mi(0,0,1,1,0,0,1,0)); tick();
    chk("ch2_sweep_count", 32'(bus.sweep_count), 4);
    apply(mi(0,0,1,1,0,0,0,0)); tick();
    chk("ch2_sweep_idle", 32'(bus.busy), 0);

    // FILL timeout after 16 cycles, then fill_done on the last allowed cycle.
    apply(mi(1,0,1,1,0,0,0,0)); tick(); tick();
    chk("to_grant", 32'(bus.start_clean), 1);
    apply(mi(0,0,1,1,1,0,0,0)); tick();
    apply(mi(0,0,1,1,0,0,0,0));
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.phase != 2'b01) break;
      n++;
      tick();
    end
    chk("fill_cycles", 32'(n), 16);
    chk("to_pulse_phase", 32'({bus.fill_timeout, bus.phase, bus.start_display}), 4'b1110);
    chk("to_count_kept", 32'(bus.sweep_count), 4);
    tick();
    chk("to_idle", 32'({bus.busy, bus.fill_timeout, bus.phase}), 4'b0011);
    apply(mi(1,0,1,1,0,0,0,0)); tick(); tick();
    apply(mi(0,0,1,1,1,0,0,0)); tick();
    apply(mi(0,0,1,1,0,0,0,0));
    repeat (15) tick();
    chk("fill_last_cycle", 32'(bus.phase), 1);
    apply(mi(0,0,1,1,0,1,0,0)); tick();
    chk("fill_done_wins", 32'({bus.phase, bus.start_display, bus.fill_timeout}), 4'b1010);
    apply(mi(0,0,1,1,0,0,1,0)); tick();
    chk("late_fill_count", 32'(bus.sweep_count), 5);
    apply(mi(0,0,1,1,0,0,0,0)); tick();

    // ch2 disabled: toggling trig_ch2 never starts a sweep.
    n = 0;
    for (int k = 0; k < 8; k++) begin
      apply(mi(0, k % 2, 1, 0, 0, 0, 0, 0));
      tick();
      if (bus.busy) n++;
    end
    chk("ch2_disabled_busy", 32'(n), 0);

    // ch1 disabled mid-sweep: sweep completes, queued ch1 request is dropped.
    apply(mi(1,0,1,0,0,0,0,0)); tick(); tick();
    chk("en_grant", 32'({bus.start_clean, bus.ch_sel}), 2'b10);
    apply(mi(0,0,1,0,0,0,0,0)); tick();
    apply(mi(1,0,1,0,0,0,0,0)); tick();
    apply(mi(1,0,0,0,0,0,0,0)); tick();
    apply(mi(1,0,0,0,1,0,0,0)); tick();
    apply(mi(1,0,0,0,0,1,0,0)); tick();
    apply(mi(1,0,0,0,0,0,1,0)); tick();
    chk("en_drop_completes", 32'(bus.sweep_count), 6);
    apply(mi(1,0,1,0,0,0,0,0));
    n = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.busy) n++;
    end
    chk("en_drop_no_resweep", 32'(n), 0);

    // Async reset in the middle of DISPLAY.
    apply(mi(0,0,1,1,0,0,0,0)); tick();
    apply(mi(1,0,1,1,0,0,0,0)); tick(); tick();
    apply(mi(0,0,1,1,1,0,0,0)); tick();
    apply(mi(0,0,1,1,0,1,0,0)); tick();
    apply(mi(0,0,1,1,0,0,0,0));
    chk("pre_reset_display", 32'(bus.phase), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", 32'(sample()), 32'(reset_o));
    tick();
    rst = 1'b0;
    tick();
    chk("post_reset_idle", 32'(sample()), 32'(reset_o));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
